// File: rtl/ipv4_pkg.sv
// Shared IPv4 definitions for the tx/rx IPv4 and UDP blocks.
package ipv4_pkg;

    localparam int unsigned IPV4_HDR_BYTES = 20;
    localparam int unsigned IPV4_HDR_BITS  = IPV4_HDR_BYTES * 8;
    localparam int unsigned IPV4_HDR_WORDS = IPV4_HDR_BYTES / 2;

    localparam logic [7:0]  IPV4_VER_IHL     = 8'h45;
    localparam logic [7:0]  IPV4_TOS         = 8'h00;
    localparam logic [15:0] IPV4_FLAGS_DF    = 16'h4000;
    localparam logic [15:0] IPV4_HDR_LEN     = 16'd20;
    localparam logic [15:0] IPV4_MAX_PAYLOAD = 16'd65515;

    localparam logic [7:0] IPV4_PROTO_TCP = 8'h06;
    localparam logic [7:0] IPV4_PROTO_UDP = 8'h11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HDR  = 2'd2,
        DATA = 2'd3
    } ipv4_state_t;

    // Header in wire order, first field in the MSBs.
    typedef struct packed {
        logic [7:0]  ver_ihl;
        logic [7:0]  tos;
        logic [15:0] total_len;
        logic [15:0] id;
        logic [15:0] flags_frag;
        logic [7:0]  ttl;
        logic [7:0]  protocol;
        logic [15:0] cksum;
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
    } ipv4_hdr_t;

    function automatic logic [15:0] ipv4_total_len(input logic [15:0] payload_len);
        return payload_len + IPV4_HDR_LEN;
    endfunction

endpackage

// File: rtl/ipv4_cksum.sv
// Two-step IPv4 header checksum: word sum, then double carry fold and invert.
// On receive, feeding the header with its checksum field gives 0 for a good header.
module ipv4_cksum
    import ipv4_pkg::*;
#(
    parameter int unsigned NWORDS = IPV4_HDR_WORDS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sum_en,
    input  logic                  fold_en,
    input  logic [NWORDS*16-1:0]  words,
    output logic [15:0]           cksum
);

    localparam int unsigned ACC_W = 16 + $clog2(NWORDS);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] sum_c;
    logic [16:0]      fold1_c;
    logic [15:0]      fold2_c;

    // Plain sum of all header words plus the two carry folds of the accumulator.
    always_comb begin
        sum_c = '0;
        for (int unsigned i = 0; i < NWORDS; i++) begin
            sum_c = sum_c + ACC_W'(16'(words >> (16 * i)));
        end
        fold1_c = 17'(acc_q[15:0]) + 17'(acc_q[ACC_W-1:16]);
        fold2_c = fold1_c[15:0] + 16'(fold1_c[16]);
    end

    // Accumulator on the sum step, inverted folded result on the fold step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
            cksum <= '0;
        end else begin
            if (sum_en) begin
                acc_q <= sum_c;
            end
            if (fold_en) begin
                cksum <= ~fold2_c;
            end
        end
    end

endmodule

// File: rtl/tx_ipv4.sv
// IPv4 transmit framer: builds a 20-byte header and streams header + payload bytes.
module tx_ipv4
    import ipv4_pkg::*;
#(
    parameter int unsigned OCT = 8,
    parameter logic [7:0]  TTL = 8'd64
) (
    input  logic           TX_CLK,
    input  logic           rst_n,
    input  logic [31:0]    ip_addr,
    input  logic [31:0]    tx_dst_ip,
    input  logic [7:0]     tx_protocol,
    input  logic [15:0]    tx_data_len,
    input  logic           tx_start,
    output logic           tx_ready,
    output logic           tx_err,
    input  logic [OCT-1:0] tx_data,
    output logic           tx_data_req,
    output logic           tx_payload_ipv4,
    output logic [OCT-1:0] tx_payload
);

    localparam int unsigned        IDX_W    = 5;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(IPV4_HDR_BYTES - 1);

    ipv4_state_t      state_q, state_d;
    logic             calc_ph_q, calc_ph_d;
    logic [IDX_W-1:0] hdr_idx_q, hdr_idx_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [7:0]       proto_q, proto_d;
    logic [15:0]      len_q, len_d;
    logic [15:0]      id_q, id_d;
    logic [OCT-1:0]   payload_q, payload_d;
    logic             valid_q, valid_d;
    logic             req_q, req_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;

    logic             sum_en_c;
    logic             fold_en_c;
    logic [15:0]      cksum_w;
    ipv4_hdr_t        hdr_c;
    ipv4_hdr_t        hdr_tx_c;
    logic [IPV4_HDR_BITS-1:0] hdr_flat_c;
    logic [7:0]       hdr_byte_c;

    // Header for the latched packet: checksum field zero for summing, real value for sending.
    always_comb begin
        hdr_c.ver_ihl    = IPV4_VER_IHL;
        hdr_c.tos        = IPV4_TOS;
        hdr_c.total_len  = ipv4_total_len(len_q);
        hdr_c.id         = id_q;
        hdr_c.flags_frag = IPV4_FLAGS_DF;
        hdr_c.ttl        = TTL;
        hdr_c.protocol   = proto_q;
        hdr_c.cksum      = '0;
        hdr_c.src_ip     = src_q;
        hdr_c.dst_ip     = dst_q;
        hdr_tx_c         = hdr_c;
        hdr_tx_c.cksum   = cksum_w;
        hdr_flat_c       = hdr_tx_c;
        hdr_byte_c       = 8'(hdr_flat_c >> {(LAST_IDX - hdr_idx_q), 3'b000});
    end

    ipv4_cksum #(
        .NWORDS (IPV4_HDR_WORDS)
    ) u_cksum (
        .clk     (TX_CLK),
        .rst_n   (rst_n),
        .sum_en  (sum_en_c),
        .fold_en (fold_en_c),
        .words   (hdr_c),
        .cksum   (cksum_w)
    );

    // Next-state and datapath decode.
    always_comb begin
        state_d   = state_q;
        calc_ph_d = calc_ph_q;
        hdr_idx_d = hdr_idx_q;
        cnt_d     = cnt_q;
        src_d     = src_q;
        dst_d     = dst_q;
        proto_d   = proto_q;
        len_d     = len_q;
        id_d      = id_q;
        payload_d = payload_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        sum_en_c  = 1'b0;
        fold_en_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (tx_start) begin
                    if (tx_data_len > IPV4_MAX_PAYLOAD) begin
                        err_d = 1'b1;
                    end else begin
                        src_d     = ip_addr;
                        dst_d     = tx_dst_ip;
                        proto_d   = tx_protocol;
                        len_d     = tx_data_len;
                        calc_ph_d = 1'b0;
                        state_d   = CALC;
                    end
                end
            end
            CALC: begin
                if (!calc_ph_q) begin
                    sum_en_c  = 1'b1;
                    calc_ph_d = 1'b1;
                end else begin
                    fold_en_c = 1'b1;
                    hdr_idx_d = '0;
                    state_d   = HDR;
                end
            end
            HDR: begin
                valid_d   = 1'b1;
                payload_d = OCT'(hdr_byte_c);
                hdr_idx_d = hdr_idx_q + IDX_W'(1);
                if (hdr_idx_q == LAST_IDX) begin
                    if (len_q == 16'd0) begin
                        id_d    = id_q + 16'd1;
                        state_d = IDLE;
                    end else begin
                        cnt_d   = len_q;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                valid_d   = 1'b1;
                payload_d = tx_data;
                cnt_d     = cnt_q - 16'd1;
                if (cnt_q == 16'd1) begin
                    id_d    = id_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
        req_d   = (state_d == DATA);
    end

    // State and output registers; reset aborts any packet in flight.
    always_ff @(posedge TX_CLK) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            calc_ph_q <= 1'b0;
            hdr_idx_q <= '0;
            cnt_q     <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            proto_q   <= '0;
            len_q     <= '0;
            id_q      <= '0;
            payload_q <= '0;
            valid_q   <= 1'b0;
            req_q     <= 1'b0;
            ready_q   <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            calc_ph_q <= calc_ph_d;
            hdr_idx_q <= hdr_idx_d;
            cnt_q     <= cnt_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            proto_q   <= proto_d;
            len_q     <= len_d;
            id_q      <= id_d;
            payload_q <= payload_d;
            valid_q   <= valid_d;
            req_q     <= req_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
        end
    end

    assign tx_ready        = ready_q;
    assign tx_err          = err_q;
    assign tx_data_req     = req_q;
    assign tx_payload_ipv4 = valid_q;
    assign tx_payload      = payload_q;

endmodule

// File: tb/tb_tx_ipv4.sv
// Scoreboard bench for tx_ipv4: expected bytes queued by stimulus, popped by a monitor.
module tb_tx_ipv4;
    import ipv4_pkg::*;

    localparam logic [31:0] SRC = 32'hC0A8010A;
    localparam logic [31:0] DST = 32'hC0A80101;

    // Hand-computed headers (wire order, first byte in the MSBs).
    localparam logic [159:0] HDR_A = 160'h4500001C_00004000_4011B775_C0A8010A_C0A80101;
    localparam logic [159:0] HDR_B = 160'h4500001C_00014000_4011B774_C0A8010A_C0A80101;
    localparam logic [159:0] HDR_C = 160'h45000014_00024000_4006B786_C0A8010A_C0A80101;
    localparam logic [159:0] HDR_D = 160'h45000018_00034000_4011B776_C0A8010A_C0A80101;
    localparam logic [159:0] HDR_F = 160'h45000014_FFFF4000_4011B77D_C0A8010A_C0A80101;
    localparam logic [159:0] HDR_G = 160'h45000014_00004000_4011B77D_C0A8010A_C0A80101;

    logic        TX_CLK;
    logic        rst_n;
    logic [31:0] ip_addr;
    logic [31:0] tx_dst_ip;
    logic [7:0]  tx_protocol;
    logic [15:0] tx_data_len;
    logic        tx_start;
    logic        tx_ready;
    logic        tx_err;
    logic [7:0]  tx_data;
    logic        tx_data_req;
    logic        tx_payload_ipv4;
    logic [7:0]  tx_payload;

    typedef struct packed {
        logic [7:0] b;
        logic       last;
    } exp_t;

    exp_t       exp_q[$];
    logic       in_pkt;
    int         checks;
    int         failures;
    int         req_cnt;
    logic [7:0] src_mem [256];
    logic [7:0] src_ptr = 8'd0;
    logic [7:0] exp_ptr;

    tx_ipv4 #(
        .OCT (8),
        .TTL (8'd64)
    ) dut (
        .TX_CLK          (TX_CLK),
        .rst_n           (rst_n),
        .ip_addr         (ip_addr),
        .tx_dst_ip       (tx_dst_ip),
        .tx_protocol     (tx_protocol),
        .tx_data_len     (tx_data_len),
        .tx_start        (tx_start),
        .tx_ready        (tx_ready),
        .tx_err          (tx_err),
        .tx_data         (tx_data),
        .tx_data_req     (tx_data_req),
        .tx_payload_ipv4 (tx_payload_ipv4),
        .tx_payload      (tx_payload)
    );

    initial TX_CLK = 1'b0;
    always #5 TX_CLK = ~TX_CLK;

    // First-word-fall-through payload source.
    assign tx_data = src_mem[src_ptr];
    always @(posedge TX_CLK) begin
        if (tx_data_req === 1'b1) src_ptr <= src_ptr + 8'd1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge TX_CLK);
            if (tx_data_req === 1'b1) req_cnt++;
            if (in_pkt) chk("contiguous_valid", 32'(tx_payload_ipv4), 32'd1);
            if (tx_payload_ipv4 === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte: got %0h expected no output", tx_payload);
                end else begin
                    e = exp_q.pop_front();
                    chk("payload_byte", 32'(tx_payload), 32'(e.b));
                    in_pkt = !e.last;
                end
            end
        end
    endtask

    task automatic push_pkt(input logic [159:0] hdr, input int nhdr, input int len);
        exp_t e;
        for (int i = 0; i < nhdr; i++) begin
            e.b    = 8'(hdr >> (8 * (19 - i)));
            e.last = (len == 0) && (i == nhdr - 1);
            exp_q.push_back(e);
        end
        for (int i = 0; i < len; i++) begin
            e.b    = src_mem[exp_ptr];
            e.last = (i == len - 1);
            exp_ptr = exp_ptr + 8'd1;
            exp_q.push_back(e);
        end
    endtask

    task automatic start_pkt(input logic [31:0] dst, input logic [7:0] proto,
                             input logic [15:0] len, input bit lat_chk);
        @(posedge TX_CLK); #1;
        for (int i = 0; i < 100 && tx_ready !== 1'b1; i++) begin
            @(posedge TX_CLK); #1;
        end
        chk("ready_before_start", 32'(tx_ready), 32'd1);
        tx_dst_ip   = dst;
        tx_protocol = proto;
        tx_data_len = len;
        tx_start    = 1'b1;
        @(posedge TX_CLK); #1;
        tx_start = 1'b0;
        chk("accepted_ready_low", 32'(tx_ready), 32'd0);
        if (lat_chk) begin
            repeat (2) @(posedge TX_CLK);
            #1;
            chk("no_valid_edge2", 32'(tx_payload_ipv4), 32'd0);
            @(posedge TX_CLK); #1;
            chk("valid_edge3", 32'(tx_payload_ipv4), 32'd1);
            chk("first_byte_45", 32'(tx_payload), 32'h45);
        end
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge TX_CLK); #1;
            done = (exp_q.size() == 0) && !in_pkt;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s_drain: got %0d bytes outstanding expected 0", name, exp_q.size());
            exp_q.delete();
            in_pkt = 1'b0;
        end
        @(negedge TX_CLK); #1;
        chk("ready_after_last", 32'(tx_ready), 32'd1);
        chk("valid_after_last", 32'(tx_payload_ipv4), 32'd0);
    endtask

    initial begin
        int req0;
        checks      = 0;
        failures    = 0;
        req_cnt     = 0;
        in_pkt      = 1'b0;
        exp_ptr     = 8'd0;
        rst_n       = 1'b0;
        tx_start    = 1'b0;
        ip_addr     = SRC;
        tx_dst_ip   = '0;
        tx_protocol = '0;
        tx_data_len = '0;
        for (int i = 0; i < 256; i++) src_mem[8'(i)] = 8'(i * 37 + 5);
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(posedge TX_CLK);
        #1;
        chk("rst_ready", 32'(tx_ready), 32'd1);
        chk("rst_valid", 32'(tx_payload_ipv4), 32'd0);
        chk("rst_req", 32'(tx_data_req), 32'd0);
        chk("rst_err", 32'(tx_err), 32'd0);
        chk("rst_payload", 32'(tx_payload), 32'h00);
        rst_n = 1'b1;

        // A: 8-byte UDP packet, id 0
        push_pkt(HDR_A, 20, 8);
        req0 = req_cnt;
        start_pkt(DST, IPV4_PROTO_UDP, 16'd8, 1'b1);
        wait_drain("A");
        chk("A_req_cycles", 32'(req_cnt - req0), 32'd8);

        // B: back-to-back, id 1
        push_pkt(HDR_B, 20, 8);
        start_pkt(DST, IPV4_PROTO_UDP, 16'd8, 1'b0);
        wait_drain("B");

        // C: zero-length TCP packet with a start during the header that must be ignored
        push_pkt(HDR_C, 20, 0);
        req0 = req_cnt;
        start_pkt(DST, IPV4_PROTO_TCP, 16'd0, 1'b0);
        repeat (5) @(posedge TX_CLK);
        #1;
        chk("C_busy_in_hdr", 32'(tx_ready), 32'd0);
        tx_dst_ip   = 32'h0A000001;
        tx_data_len = 16'd4;
        tx_start    = 1'b1;
        @(posedge TX_CLK); #1;
        tx_start = 1'b0;
        wait_drain("C");
        chk("C_no_req", 32'(req_cnt - req0), 32'd0);
        repeat (30) @(posedge TX_CLK);

        // Oversize length rejected
        #1;
        tx_data_len = 16'hFFFF;
        tx_start    = 1'b1;
        @(posedge TX_CLK); #1;
        tx_start = 1'b0;
        chk("err_pulse", 32'(tx_err), 32'd1);
        chk("err_ready", 32'(tx_ready), 32'd1);
        @(posedge TX_CLK); #1;
        chk("err_one_cycle", 32'(tx_err), 32'd0);
        repeat (25) @(posedge TX_CLK);

        // D: id 3 (unchanged by the rejected start), reset at header byte 7
        push_pkt(HDR_D, 7, 0);
        start_pkt(DST, IPV4_PROTO_UDP, 16'd4, 1'b0);
        repeat (9) @(posedge TX_CLK);
        #1;
        rst_n = 1'b0;
        @(posedge TX_CLK); #1;
        chk("D_rst_valid", 32'(tx_payload_ipv4), 32'd0);
        chk("D_rst_payload", 32'(tx_payload), 32'h00);
        chk("D_rst_req", 32'(tx_data_req), 32'd0);
        rst_n = 1'b1;
        @(posedge TX_CLK); #1;
        chk("D_ready_after_rst", 32'(tx_ready), 32'd1);

        // E: id restarts at 0 after reset
        push_pkt(HDR_A, 20, 8);
        start_pkt(DST, IPV4_PROTO_UDP, 16'd8, 1'b1);
        wait_drain("E");

        // F/G: id wrap FFFF -> 0000
        @(posedge TX_CLK); #1;
        force dut.id_q = 16'hFFFF;
        @(posedge TX_CLK); #1;
        release dut.id_q;
        push_pkt(HDR_F, 20, 0);
        start_pkt(DST, IPV4_PROTO_UDP, 16'd0, 1'b0);
        wait_drain("F");
        push_pkt(HDR_G, 20, 0);
        start_pkt(DST, IPV4_PROTO_UDP, 16'd0, 1'b0);
        wait_drain("G");

        repeat (5) @(posedge TX_CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
